// File: rtl/axi_proxy_mc_pkg.sv
// Shared types and constants for the multi-channel AXI proxy: FSM states,
// register map, response codes and packet field offsets.
package axi_proxy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_PRELOAD = 2'd2
    } op_t;

    localparam logic [4:0] REG_ADDR    = 5'd0;
    localparam logic [4:0] REG_PROXY   = 5'd1;
    localparam logic [4:0] REG_STATUS  = 5'd2;
    localparam logic [4:0] REG_TIMEOUT = 5'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_DATA_LSB = 32;
    localparam int REQ_MODE_BIT = 64;
    localparam int RSP_ADDR_LSB = 0;
    localparam int RSP_DATA_LSB = 32;
    localparam int RSP_RESP_LSB = 64;

    localparam logic [31:0] READ_FILL = 32'hDEAD_BEEF;

    // Register index covers a 128-byte window of 32-bit words.
    function automatic logic [4:0] reg_index(input logic [31:0] addr);
        return addr[6:2];
    endfunction

endpackage

// File: rtl/axi_proxy_mc_if.sv
// Bundle of the ASHI register port, the AXI-Stream request fan-out and the
// response stream, plus a debug view of the proxy FSM state.
interface axi_proxy_mc_if #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 512,
    parameter int IN_W   = 256
);
    import axi_proxy_pkg::*;

    // AXI-Stream beats transfer on a clock edge where tvalid and tready are both
    // high; once raised, tvalid and tdata hold until that edge.
    logic                    preload_complete;
    logic [NUM_CH*OUT_W-1:0] axis_out_tdata;
    logic [NUM_CH-1:0]       axis_out_tvalid;
    logic [NUM_CH-1:0]       axis_out_tready;
    logic [IN_W-1:0]         axis_in_tdata;
    logic                    axis_in_tvalid;
    logic                    axis_in_tready;
    logic [31:0]             ashi_waddr;
    logic [31:0]             ashi_wdata;
    logic                    ashi_write;
    logic [1:0]              ashi_wresp;
    logic                    ashi_widle;
    logic [31:0]             ashi_raddr;
    logic                    ashi_read;
    logic [31:0]             ashi_rdata;
    logic [1:0]              ashi_rresp;
    logic                    ashi_ridle;
    state_t                  dbg_state;

    modport slave (
        input  preload_complete, axis_out_tready, axis_in_tdata, axis_in_tvalid,
        input  ashi_waddr, ashi_wdata, ashi_write, ashi_raddr, ashi_read,
        output axis_out_tdata, axis_out_tvalid, axis_in_tready,
        output ashi_wresp, ashi_widle, ashi_rdata, ashi_rresp, ashi_ridle, dbg_state
    );

    modport master (
        output preload_complete, axis_out_tready, axis_in_tdata, axis_in_tvalid,
        output ashi_waddr, ashi_wdata, ashi_write, ashi_raddr, ashi_read,
        input  axis_out_tdata, axis_out_tvalid, axis_in_tready,
        input  ashi_wresp, ashi_widle, ashi_rdata, ashi_rresp, ashi_ridle, dbg_state
    );

endinterface

// File: rtl/axi_proxy_mc_fanout.sv
// Per-channel tvalid tracking for a request broadcast to NUM_CH lockstep
// channels; each bit drops on its own handshake.
module axis_lockstep_fanout #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_abort,
    input  logic [NUM_CH-1:0] i_tready,
    output logic [NUM_CH-1:0] o_tvalid,
    output logic              o_all_done
);
    logic [NUM_CH-1:0] r_tvalid;

    always_ff @(posedge clk) begin
        if (reset || i_abort) begin
            r_tvalid <= '0;
        end else if (i_load) begin
            r_tvalid <= '1;
        end else begin
            r_tvalid <= r_tvalid & ~i_tready;
        end
    end

    // True when no channel will still be pending after this clock edge.
    assign o_all_done = ~|(r_tvalid & ~i_tready);
    assign o_tvalid   = r_tvalid;

endmodule

// File: rtl/axi_proxy_mc.sv
// ASHI-to-AXI-Stream proxy: local config registers, a PROXY register that
// issues a request packet on NUM_CH channels and waits for the matching response.
module axi_proxy_mc
    import axi_proxy_pkg::*;
#(
    parameter int          NUM_CH          = 2,
    parameter int          OUT_W           = 512,
    parameter int          IN_W            = 256,
    parameter logic [7:0]  PKT_TYPE        = 8'h01,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1_000_000,
    parameter logic [31:0] PRELOAD_ADDR    = 32'h0000_1000,
    parameter logic [31:0] PRELOAD_VALU    = 32'h0000_000F
) (
    input logic          clk,
    input logic          reset,
    axi_proxy_mc_if.slave bus
);
    state_t            r_state, w_state_nxt;
    op_t               r_op, w_issue_op;
    logic [31:0]       r_addr_reg, r_timeout_reg, r_timer;
    logic              r_to_en, r_to_flag, r_pend, r_tready;
    logic [15:0]       r_to_cnt;
    logic [31:0]       r_req_addr, r_req_data;
    logic              r_req_mode;
    logic [1:0]        r_wresp, r_rresp;
    logic [31:0]       r_rdata;

    logic              w_issue, w_local_wr, w_local_rd, w_send_done, w_rsp_done, w_timeout;
    logic [4:0]        w_widx, w_ridx;
    logic [31:0]       w_rsp_addr, w_rsp_data;
    logic [1:0]        w_rsp_resp;
    logic              w_rsp_hit, w_expire, w_fan_done;
    logic [31:0]       w_nxt_addr, w_nxt_data, w_rd_val;
    logic              w_nxt_mode, w_wr_ok, w_rd_ok;
    logic [OUT_W-1:0]  w_req;
    logic [NUM_CH*OUT_W-1:0] w_out_tdata;
    logic              w_unused_rsp;

    assign w_widx      = reg_index(bus.ashi_waddr);
    assign w_ridx      = reg_index(bus.ashi_raddr);
    assign w_rsp_addr  = bus.axis_in_tdata[RSP_ADDR_LSB +: 32];
    assign w_rsp_data  = bus.axis_in_tdata[RSP_DATA_LSB +: 32];
    assign w_rsp_resp  = bus.axis_in_tdata[RSP_RESP_LSB +: 2];
    assign w_unused_rsp = ^bus.axis_in_tdata;
    // Responses for other addresses are stale and are swallowed while waiting.
    assign w_rsp_hit   = bus.axis_in_tvalid && r_tready && (w_rsp_addr == r_req_addr);
    assign w_expire    = r_to_en && (r_timer == 32'd1);

    axis_lockstep_fanout #(.NUM_CH(NUM_CH)) u_fanout (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_issue),
        .i_abort    (w_timeout),
        .i_tready   (bus.axis_out_tready),
        .o_tvalid   (bus.axis_out_tvalid),
        .o_all_done (w_fan_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_op  = OP_WRITE;
        w_local_wr  = 1'b0;
        w_local_rd  = 1'b0;
        w_send_done = 1'b0;
        w_rsp_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ashi_write) begin
                    if (w_widx == REG_PROXY) begin
                        w_issue     = 1'b1;
                        w_issue_op  = OP_WRITE;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_local_wr = 1'b1;
                    end
                end else if (bus.ashi_read) begin
                    if (w_ridx == REG_PROXY) begin
                        w_issue     = 1'b1;
                        w_issue_op  = OP_READ;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_local_rd = 1'b1;
                    end
                end else if (r_pend) begin
                    w_issue     = 1'b1;
                    w_issue_op  = OP_PRELOAD;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_fan_done) begin
                    w_send_done = 1'b1;
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (w_rsp_hit) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_addr = r_addr_reg;
        w_nxt_data = bus.ashi_wdata;
        w_nxt_mode = 1'b0;
        case (w_issue_op)
            OP_READ: begin
                w_nxt_data = READ_FILL;
                w_nxt_mode = 1'b1;
            end
            OP_PRELOAD: begin
                w_nxt_addr = PRELOAD_ADDR;
                w_nxt_data = PRELOAD_VALU;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_wr_ok  = (w_widx == REG_ADDR) || (w_widx == REG_STATUS) || (w_widx == REG_TIMEOUT);
        w_rd_ok  = 1'b1;
        w_rd_val = 32'd0;
        case (w_ridx)
            REG_ADDR:    w_rd_val = r_addr_reg;
            REG_STATUS:  w_rd_val = {r_to_cnt, 15'd0, r_to_flag};
            REG_TIMEOUT: w_rd_val = r_timeout_reg;
            default:     w_rd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op          <= OP_WRITE;
            r_addr_reg    <= 32'd0;
            r_timeout_reg <= TIMEOUT_DEFAULT;
            r_timer       <= 32'd0;
            r_to_en       <= 1'b0;
            r_to_flag     <= 1'b0;
            r_to_cnt      <= 16'd0;
            r_pend        <= 1'b0;
            r_tready      <= 1'b0;
            r_req_addr    <= 32'd0;
            r_req_data    <= 32'd0;
            r_req_mode    <= 1'b0;
            r_wresp       <= RESP_OKAY;
            r_rresp       <= RESP_OKAY;
            r_rdata       <= 32'd0;
        end else begin
            // A strobe coinciding with the preload issue re-arms the latch.
            r_pend <= bus.preload_complete || (r_pend && !(w_issue && w_issue_op == OP_PRELOAD));

            if (w_issue) begin
                r_op       <= w_issue_op;
                r_req_addr <= w_nxt_addr;
                r_req_data <= w_nxt_data;
                r_req_mode <= w_nxt_mode;
                r_timer    <= r_timeout_reg;
                r_to_en    <= |r_timeout_reg;
            end else if (r_state != ST_IDLE && r_to_en) begin
                r_timer <= r_timer - 32'd1;
            end

            if (w_send_done) begin
                r_tready <= 1'b1;
            end else if (w_rsp_done || w_timeout) begin
                r_tready <= 1'b0;
            end

            if (w_local_wr) begin
                r_wresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                case (w_widx)
                    REG_ADDR:    r_addr_reg    <= bus.ashi_wdata;
                    REG_TIMEOUT: r_timeout_reg <= bus.ashi_wdata;
                    REG_STATUS: begin
                        r_to_flag <= 1'b0;
                        r_to_cnt  <= 16'd0;
                    end
                    default: ;
                endcase
            end

            if (w_local_rd) begin
                r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_rdata <= w_rd_val;
            end

            if (w_rsp_done) begin
                if (r_op == OP_WRITE) begin
                    r_wresp <= w_rsp_resp;
                end else if (r_op == OP_READ) begin
                    r_rresp <= w_rsp_resp;
                    r_rdata <= w_rsp_data;
                end
            end

            if (w_timeout) begin
                r_to_flag <= 1'b1;
                if (r_to_cnt != 16'hFFFF) begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
                if (r_op == OP_WRITE) begin
                    r_wresp <= RESP_DECERR;
                end else if (r_op == OP_READ) begin
                    r_rresp <= RESP_DECERR;
                    r_rdata <= 32'd0;
                end
            end
        end
    end

    always_comb begin
        w_req = '0;
        w_req[REQ_ADDR_LSB +: 32] = r_req_addr;
        w_req[REQ_DATA_LSB +: 32] = r_req_data;
        w_req[REQ_MODE_BIT]       = r_req_mode;
        w_req[OUT_W-1 -: 8]       = PKT_TYPE;
        w_out_tdata               = '0;
        w_out_tdata[OUT_W-1:0]    = w_req;
    end

    assign bus.axis_out_tdata = w_out_tdata;
    assign bus.axis_in_tready = r_tready;
    assign bus.ashi_wresp     = r_wresp;
    assign bus.ashi_rresp     = r_rresp;
    assign bus.ashi_rdata     = r_rdata;
    assign bus.ashi_widle     = (r_state == ST_IDLE) && !bus.ashi_write;
    assign bus.ashi_ridle     = (r_state == ST_IDLE) && !bus.ashi_read;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_axi_proxy_mc.sv
// Directed bench for axi_proxy_mc: drivers push expected ASHI responses and
// request packets into queues, a negedge monitor pops and compares them.
module tb_axi_proxy_mc;
    import axi_proxy_pkg::*;

    localparam int          NUM_CH = 2;
    localparam int          OUT_W  = 512;
    localparam int          IN_W   = 256;
    localparam logic [7:0]  PKT    = 8'h01;
    localparam logic [31:0] TO_DEF = 32'd1_000_000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_proxy_mc_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .IN_W(IN_W)) bus ();

    axi_proxy_mc #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .IN_W(IN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [OUT_W-1:0] exp_req_q[$];
    logic [1:0]       exp_w_q[$];
    logic [33:0]      exp_r_q[$];
    logic             w_out = 1'b0;
    logic             r_out = 1'b0;
    logic [31:0]      m_addr = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] mk_req(input logic [31:0] a, input logic [31:0] d, input logic m);
        logic [OUT_W-1:0] r;
        r = '0;
        r[31:0] = a;
        r[63:32] = d;
        r[64] = m;
        r[OUT_W-1 -: 8] = PKT;
        return r;
    endfunction

    // Monitor: ASHI completions and channel-0 request beats.
    always @(negedge clk) begin
        if (reset) begin
            w_out = 1'b0;
            r_out = 1'b0;
        end else begin
            if (w_out && bus.ashi_widle) begin
                if (exp_w_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wresp_unexpected: got %0h expected none", bus.ashi_wresp);
                end else begin
                    check("wresp", 64'(bus.ashi_wresp), 64'(exp_w_q.pop_front()));
                end
                w_out = 1'b0;
            end
            if (r_out && bus.ashi_ridle) begin
                if (exp_r_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rresp_unexpected: got %0h expected none", bus.ashi_rresp);
                end else begin
                    check("rresp_rdata", 64'({bus.ashi_rresp, bus.ashi_rdata}), 64'(exp_r_q.pop_front()));
                end
                r_out = 1'b0;
            end
            if (bus.ashi_write) w_out = 1'b1;
            if (bus.ashi_read)  r_out = 1'b1;
            if (bus.axis_out_tvalid[0] && bus.axis_out_tready[0]) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected: got %h expected none", bus.axis_out_tdata[OUT_W-1:0]);
                end else begin
                    logic [OUT_W-1:0] e;
                    e = exp_req_q.pop_front();
                    if (bus.axis_out_tdata[OUT_W-1:0] !== e) begin
                        failures++;
                        $display("FAIL req_tdata: got %h expected %h", bus.axis_out_tdata[OUT_W-1:0], e);
                    end
                end
                check("other_ch_zero", 64'(|bus.axis_out_tdata[NUM_CH*OUT_W-1:OUT_W]), 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.ashi_widle && bus.ashi_ridle && bus.dbg_state == ST_IDLE) && n < 300);
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL wait_idle_timeout: got state %0d expected %0d", bus.dbg_state, ST_IDLE);
        end
    endtask

    task automatic ashi_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er, input bit push_rsp);
        wait_idle();
        @(posedge clk); #1;
        bus.ashi_waddr = a;
        bus.ashi_wdata = d;
        bus.ashi_write = 1'b1;
        if (push_rsp) exp_w_q.push_back(er);
        if (a[6:2] == 5'd1) exp_req_q.push_back(mk_req(m_addr, d, 1'b0));
        if (a[6:2] == 5'd0) m_addr = d;
        @(posedge clk); #1;
        bus.ashi_write = 1'b0;
    endtask

    task automatic ashi_rd(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
        wait_idle();
        @(posedge clk); #1;
        bus.ashi_raddr = a;
        bus.ashi_read  = 1'b1;
        exp_r_q.push_back({er, ed});
        if (a[6:2] == 5'd1) exp_req_q.push_back(mk_req(m_addr, 32'hDEAD_BEEF, 1'b1));
        @(posedge clk); #1;
        bus.ashi_read = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.axis_in_tready && n < 300);
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL rsp_tready_timeout: got %0d expected 1", bus.axis_in_tready);
        end
        @(posedge clk); #1;
        bus.axis_in_tdata = '0;
        bus.axis_in_tdata[31:0]  = a;
        bus.axis_in_tdata[63:32] = d;
        bus.axis_in_tdata[65:64] = r;
        bus.axis_in_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.axis_in_tvalid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.preload_complete = 1'b0;
        bus.axis_out_tready  = 2'b11;
        bus.axis_in_tdata    = '0;
        bus.axis_in_tvalid   = 1'b0;
        bus.ashi_waddr = 32'd0; bus.ashi_wdata = 32'd0; bus.ashi_write = 1'b0;
        bus.ashi_raddr = 32'd0; bus.ashi_read  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
        check("rst_tready", 64'(bus.axis_in_tready), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        check("rst_wresp_rresp_rdata", 64'({bus.ashi_wresp, bus.ashi_rresp, bus.ashi_rdata}), 64'd0);
        check("rst_idle", 64'({bus.ashi_widle, bus.ashi_ridle}), 64'd3);

        // Local register map and unmapped indices
        ashi_rd(32'hC, RESP_OKAY, TO_DEF);
        ashi_wr(32'h14, 32'h1, RESP_SLVERR, 1'b1);
        ashi_rd(32'h14, RESP_SLVERR, 32'd0);

        // Basic proxy write at minimum latency: response already waiting
        ashi_wr(32'h0, 32'h2000, RESP_OKAY, 1'b1);
        bus.axis_in_tdata = '0;
        bus.axis_in_tdata[31:0] = 32'h2000;
        bus.axis_in_tvalid = 1'b1;
        ashi_wr(32'h4, 32'h55, RESP_OKAY, 1'b1);
        @(negedge clk);
        check("t1_c1_state", 64'(bus.dbg_state), 64'(ST_SEND));
        check("t1_c1_tvalid", 64'(bus.axis_out_tvalid), 64'h3);
        @(negedge clk);
        check("t1_c2_state_tready", 64'({bus.dbg_state, bus.axis_in_tready}), 64'({ST_WAIT_RSP, 1'b1}));
        check("t1_c2_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
        @(negedge clk);
        check("t1_c3_idle", 64'({bus.ashi_widle, bus.axis_in_tready}), 64'h2);
        @(posedge clk); #1;
        bus.axis_in_tvalid = 1'b0;

        // Channel 1 slow to accept
        bus.axis_out_tready = 2'b01;
        ashi_wr(32'h4, 32'h66, RESP_OKAY, 1'b1);
        @(negedge clk);
        check("t2_c1_tvalid", 64'(bus.axis_out_tvalid), 64'h3);
        @(negedge clk);
        check("t2_c2_tvalid", 64'(bus.axis_out_tvalid), 64'h2);
        repeat (8) @(negedge clk);
        check("t2_c10_tready", 64'({bus.dbg_state, bus.axis_in_tready}), 64'({ST_SEND, 1'b0}));
        @(posedge clk); #1;
        bus.axis_out_tready = 2'b11;
        @(negedge clk);
        check("t2_hs_cycle", 64'({bus.axis_out_tvalid, bus.axis_in_tready}), 64'h4);
        @(negedge clk);
        check("t2_after_hs", 64'({bus.axis_out_tvalid, bus.axis_in_tready}), 64'h1);
        send_rsp(32'h2000, 32'h0, RESP_OKAY);

        // Proxy read with a stale response in front
        ashi_rd(32'h4, RESP_OKAY, 32'hCAFE);
        send_rsp(32'h1234, 32'hBAD, RESP_OKAY);
        @(negedge clk);
        check("t3_stale_dropped", 64'({bus.dbg_state, bus.axis_in_tready}), 64'({ST_WAIT_RSP, 1'b1}));
        send_rsp(32'h2000, 32'hCAFE, RESP_OKAY);

        // Timeout of 50 cycles with no response
        ashi_wr(32'hC, 32'd50, RESP_OKAY, 1'b1);
        ashi_wr(32'h4, 32'h77, RESP_DECERR, 1'b1);
        repeat (50) @(negedge clk);
        check("t4_c50_waiting", 64'(bus.dbg_state), 64'(ST_WAIT_RSP));
        @(negedge clk);
        check("t4_c51_idle", 64'({bus.dbg_state, bus.axis_in_tready, bus.ashi_widle}), 64'({ST_IDLE, 1'b0, 1'b1}));
        ashi_rd(32'h8, RESP_OKAY, 32'h0001_0001);
        ashi_wr(32'h8, 32'hFFFF_FFFF, RESP_OKAY, 1'b1);
        ashi_rd(32'h8, RESP_OKAY, 32'h0);
        ashi_wr(32'hC, 32'd0, RESP_OKAY, 1'b1);

        // Preload strobed twice during a busy proxy write
        ashi_wr(32'h4, 32'h99, RESP_OKAY, 1'b1);
        bus.preload_complete = 1'b1;
        exp_req_q.push_back(mk_req(32'h1000, 32'hF, 1'b0));
        @(posedge clk); #1;
        bus.preload_complete = 1'b0;
        @(posedge clk); #1;
        bus.preload_complete = 1'b1;
        @(posedge clk); #1;
        bus.preload_complete = 1'b0;
        send_rsp(32'h2000, 32'h0, RESP_OKAY);
        @(negedge clk);
        check("t5_back_idle", 64'(bus.dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        check("t5_preload_issued", 64'({bus.dbg_state, bus.axis_out_tvalid}), 64'({ST_SEND, 2'b11}));
        send_rsp(32'h1000, 32'h0, RESP_SLVERR);
        wait_idle();
        check("t5_preload_rsp_discarded", 64'({bus.ashi_wresp, bus.ashi_rresp}), 64'd0);
        repeat (3) @(negedge clk);
        check("t5_single_preload", 64'(bus.axis_out_tvalid), 64'd0);

        // Reset while waiting for a response
        ashi_wr(32'hC, 32'd77, RESP_OKAY, 1'b1);
        ashi_wr(32'h4, 32'h5A, RESP_OKAY, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_in_wait", 64'(bus.dbg_state), 64'(ST_WAIT_RSP));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_addr = 32'd0;
        @(negedge clk);
        check("t6_after_reset", 64'({bus.dbg_state, bus.axis_in_tready, bus.axis_out_tvalid}), 64'd0);
        check("t6_wresp_cleared", 64'(bus.ashi_wresp), 64'(RESP_OKAY));
        ashi_rd(32'hC, RESP_OKAY, TO_DEF);
        ashi_rd(32'h0, RESP_OKAY, 32'h0);
        ashi_wr(32'h0, 32'h3000, RESP_OKAY, 1'b1);
        ashi_wr(32'h4, 32'hA5, RESP_OKAY, 1'b1);
        send_rsp(32'h3000, 32'h0, RESP_OKAY);
        wait_idle();
        @(negedge clk);

        check("exp_w_q_empty", 64'(exp_w_q.size()), 64'd0);
        check("exp_r_q_empty", 64'(exp_r_q.size()), 64'd0);
        check("exp_req_q_empty", 64'(exp_req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
